ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Upstream feeder for the BCD-to-segment decoder on a multiplexed 7-seg display.
//  Accepts a binary value and converts it to BCD with a sequential double-dabble engine.
//  Time-multiplexes the resulting digits onto a common-anode display: one digit nibble and one anode at a time.
//  The digit nibble feeds the segment decoder combinationally; the anodes drive the display directly.
// PARAMETERS
//  N_DIGITS     4       number of display digits / anodes
//  BIN_W        14      width of binary input value
//  REFRESH_DIV  100000  clk cycles each digit stays lit (>=1)
//  BLANK_LZ     1       1 = blank leading zeros (digit 0 never blanked)
// PORTS
//  clk      in   1            system clock, rising edge
//  rst      in   1            synchronous, active-high reset
//  value    in   BIN_W        binary number to display
//  load     in   1            request: convert and show value (sampled when busy=0)
//  busy     out  1            conversion in progress; load ignored
//  ovf      out  1            last accepted value exceeded 10^N_DIGITS-1
//  digit    out  4            BCD nibble of currently scanned digit -> segment decoder
//  anode    out  N_DIGITS     active-low anode enables, at most one low
//  digit_idx out $clog2(N_DIGITS)  index of currently scanned digit (0 = least significant)
// BEHAVIOUR
//  Reset (sync, priority over all): disp=0, idx=0, div_cnt=0, busy=0, ovf=0, any conversion aborted.
//   Outputs after reset: digit=0, digit_idx=0, anode={1..1,0} (digit 0 lit).
//  Conversion FSM, states IDLE/CONV:
//   IDLE & load: capture value into shift reg; clear BCD acc; bit_cnt=0; ovf<=(value>10^N_DIGITS-1); go CONV.
//    busy=1 from the next cycle.
//   CONV, each edge: in every BCD nibble, add 3 if >=5; then shift {acc,shreg} left by 1; bit_cnt++.
//   The edge with bit_cnt==BIN_W-1 performs the final shift and goes to IDLE.
//    Same edge: disp <= shifted acc, or all nibbles 9 if ovf; busy <= 0.
//   busy is high for exactly BIN_W cycles. New digits are visible the cycle after busy falls.
//   load while busy: ignored, no queueing. load in the same cycle busy falls: ignored (busy still 1 when sampled).
//   disp holds the previous value for the whole conversion; no partial results are shown.
//  Scanner, free-running and independent of the FSM:
//   div_cnt counts 0..REFRESH_DIV-1 and wraps.
//   On the wrap edge, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//   With REFRESH_DIV=1, idx advances every cycle.
//  Output decode (combinational from registers only):
//   digit=disp[idx]; digit_idx=idx; anode=~(1<<idx).
//   If BLANK_LZ and idx>0 and disp[idx] and all higher digits are 0: anode=all 1s; digit still driven.
//  Arithmetic: BCD acc is 4*N_DIGITS bits; bits shifted beyond the MSB are discarded (covered by ovf saturation).
// TESTING (REFRESH_DIV=4, N_DIGITS=4, BIN_W=14)
//  Reset, no load -> anode cycles 1110,1111,1111,1111 (BLANK_LZ), 4 clks each; digit=0 throughout.
//  load value=1234 -> busy high 14 cycles; then scan yields digits 4,3,2,1, anodes 1110,1101,1011,0111; ovf=0.
//  load 10000 -> ovf=1, all digits 9, all anodes enabled in turn; next load 7 -> ovf=0; only anode0 lit, digit=7.
//  load 42, pulse load=9 during busy -> display shows 42, not 9; busy never extends past 14 cycles.
//  Assert rst mid-conversion of 5678 -> busy=0 next cycle; display blank-zero state; no 5678 ever appears.
//  Load 0 and 9999 -> display 0 (digit0 lit only) and 9999 (no saturation, ovf=0).

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Upstream feeder for a BCD-to-7-segment decoder on a multiplexed,
//   common-anode display. A binary value is converted to BCD by a sequential
//   double-dabble engine (one bit per clock). The finished digits are then
//   time-multiplexed onto the display, one digit nibble and one anode at a
//   time.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset (priority over everything)
//   value      in   binary number to display (BIN_W bits)
//   load       in   convert and show value; sampled only while busy=0
//   busy       out  conversion in progress, load ignored
//   ovf        out  last accepted value exceeded 10^N_DIGITS-1
//   digit      out  BCD nibble of the currently scanned digit
//   anode      out  active-low anode enables, at most one low
//   digit_idx  out  index of the scanned digit (0 = least significant)
module ssd_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1,
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    value,
    input  logic                load,
    output logic                busy,
    output logic                ovf,
    output logic [3:0]          digit,
    output logic [N_DIGITS-1:0] anode,
    output logic [IDX_W-1:0]    digit_idx
);

    localparam int ACC_W = 4 * N_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Largest value that fits in N_DIGITS decimal digits.
    localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Saturated display pattern used when the value does not fit.
    function automatic logic [ACC_W-1:0] all_nines();
        logic [ACC_W-1:0] r;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                   state;
    logic [BIN_W-1:0]         shreg;
    logic [ACC_W-1:0]         acc;
    logic [CNT_W-1:0]         bit_cnt;
    logic [ACC_W-1:0]         disp;
    logic [IDX_W-1:0]         idx;
    logic [DIV_W-1:0]         div_cnt;

    logic [ACC_W+BIN_W-1:0]   shifted;
    logic [ACC_W-1:0]         acc_nxt;
    logic [BIN_W-1:0]         shreg_nxt;
    logic                     upper_zero;
    logic [N_DIGITS-1:0]      one_hot;

    // One double-dabble step: correct nibbles, then shift {acc,shreg} left.
    // Bits leaving the top of acc are dropped; ovf saturation covers them.
    always_comb begin
        shifted   = {add3_all(acc), shreg} << 1;
        acc_nxt   = shifted[ACC_W+BIN_W-1:BIN_W];
        shreg_nxt = shifted[BIN_W-1:0];
    end

    // Conversion FSM. disp is only written on the final step so a conversion
    // in flight never shows partial digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            disp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= value;
                        acc     <= '0;
                        bit_cnt <= '0;
                        ovf     <= (64'(value) > MAX_VAL);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_nxt;
                    shreg   <= shreg_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BIN_W - 1)) begin
                        disp  <= ovf ? all_nines() : acc_nxt;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running digit scanner, independent of the conversion FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Output decode, purely from registers. A digit is a leading zero when it
    // and every more significant digit are zero; digit 0 is never blanked.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        digit        = disp[int'(idx)*4 +: 4];
        digit_idx    = idx;
        if (BLANK_LZ && idx != '0 && upper_zero) begin
            anode = '1;
        end else begin
            anode = ~one_hot;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;

    int errors;
    int checks;

    // Observations gathered over one full scan, indexed by digit_idx.
    logic [3:0] seen_digit [4];
    logic [3:0] seen_anode [4];
    int         seen_cnt   [4];
    int         seen_bad;

    ssd_scan_driver #(
        .N_DIGITS   (4),
        .BIN_W      (14),
        .REFRESH_DIV(4),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .ovf      (ovf),
        .digit    (digit),
        .anode    (anode),
        .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record digit/anode per index over 16 cycles (4 digits x 4 clks).
    // Any index showing two different values within the scan is flagged.
    task automatic capture_scan();
        for (int i = 0; i < 4; i++) begin
            seen_cnt[i]   = 0;
            seen_digit[i] = 4'hx;
            seen_anode[i] = 4'hx;
        end
        seen_bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (seen_cnt[digit_idx] != 0 &&
                (seen_digit[digit_idx] !== digit || seen_anode[digit_idx] !== anode))
                seen_bad++;
            seen_digit[digit_idx] = digit;
            seen_anode[digit_idx] = anode;
            seen_cnt[digit_idx]++;
            step();
        end
    endtask

    // Issue a load and count the busy cycles that follow.
    task automatic do_load(input logic [13:0] v, output int nbusy);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b0;
        value = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b ovf=%b want busy=0 ovf=0", busy, ovf);
        end
        checks++;
        if (digit !== 4'd0 || digit_idx !== 2'd0 || anode !== 4'b1110) begin
            errors++;
            $display("FAIL reset_outputs digit=%0d idx=%0d anode=%b want 0 0 1110",
                     digit, digit_idx, anode);
        end
        // idx must stay 0 for exactly 4 cycles after reset, then advance.
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (digit_idx !== ((c < 4) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL reset_scan_timing cycle=%0d idx=%0d want %0d",
                         c, digit_idx, (c < 4) ? 0 : 1);
            end
            step();
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_cnt[i] != 4 || seen_digit[i] !== 4'd0 ||
                seen_anode[i] !== ((i == 0) ? 4'b1110 : 4'b1111)) begin
                errors++;
                $display("FAIL reset_scan idx=%0d cnt=%0d digit=%0d anode=%b want 4 0 %b",
                         i, seen_cnt[i], seen_digit[i], seen_anode[i],
                         (i == 0) ? 4'b1110 : 4'b1111);
            end
        end
    endtask

    task automatic test_convert_1234();
        int nb;
        logic [3:0] ed [4];
        logic [3:0] ea [4];
        ed = '{4'd4, 4'd3, 4'd2, 4'd1};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_load(14'd1234, nb);
        checks++;
        if (nb != 14) begin
            errors++;
            $display("FAIL busy_len_1234 got=%0d want=14", nb);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_1234 got=%b want=0", ovf);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== ed[i] || seen_anode[i] !== ea[i]) begin
                errors++;
                $display("FAIL scan_1234 idx=%0d digit=%0d anode=%b want %0d %b",
                         i, seen_digit[i], seen_anode[i], ed[i], ea[i]);
            end
        end
        checks++;
        if (seen_bad != 0) begin
            errors++;
            $display("FAIL scan_1234_stable glitches=%0d want 0", seen_bad);
        end
    endtask

    task automatic test_overflow();
        int nb;
        logic [3:0] ea [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_load(14'd10000, nb);
        checks++;
        if (ovf !== 1'b1 || nb != 14) begin
            errors++;
            $display("FAIL ovf_10000 ovf=%b busy_len=%0d want 1 14", ovf, nb);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== 4'd9 || seen_anode[i] !== ea[i]) begin
                errors++;
                $display("FAIL scan_10000 idx=%0d digit=%0d anode=%b want 9 %b",
                         i, seen_digit[i], seen_anode[i], ea[i]);
            end
        end
        do_load(14'd7, nb);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_7 got=%b want=0", ovf);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== ((i == 0) ? 4'd7 : 4'd0) ||
                seen_anode[i] !== ((i == 0) ? 4'b1110 : 4'b1111)) begin
                errors++;
                $display("FAIL scan_7 idx=%0d digit=%0d anode=%b want %0d %b",
                         i, seen_digit[i], seen_anode[i], (i == 0) ? 7 : 0,
                         (i == 0) ? 4'b1110 : 4'b1111);
            end
        end
    endtask

    task automatic test_load_during_busy();
        int nb;
        logic [3:0] ed [4];
        logic [3:0] ea [4];
        ed = '{4'd2, 4'd4, 4'd0, 4'd0};
        ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        value = 14'd42;
        load  = 1'b1;
        step();
        load = 1'b0;
        nb = 0;
        // Pulse load=9 mid-conversion and again on the cycle busy falls.
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (nb == 4 || nb == 14) begin
                value = 14'd9;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        checks++;
        if (nb != 14) begin
            errors++;
            $display("FAIL busy_len_42 got=%0d want=14", nb);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_42 got=%b want=0", busy);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== ed[i] || seen_anode[i] !== ea[i]) begin
                errors++;
                $display("FAIL scan_42 idx=%0d digit=%0d anode=%b want %0d %b",
                         i, seen_digit[i], seen_anode[i], ed[i], ea[i]);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        value = 14'd5678;
        load  = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0 || digit !== 4'd0 ||
            digit_idx !== 2'd0 || anode !== 4'b1110) begin
            errors++;
            $display("FAIL rst_mid busy=%b ovf=%b digit=%0d idx=%0d anode=%b want 0 0 0 0 1110",
                     busy, ovf, digit, digit_idx, anode);
        end
        capture_scan();
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== 4'd0 ||
                seen_anode[i] !== ((i == 0) ? 4'b1110 : 4'b1111) || seen_bad != 0) begin
                errors++;
                $display("FAIL rst_mid_scan idx=%0d digit=%0d anode=%b glitches=%0d want 0 %b 0",
                         i, seen_digit[i], seen_anode[i], seen_bad,
                         (i == 0) ? 4'b1110 : 4'b1111);
            end
        end
    endtask

    task automatic test_bounds();
        int nb;
        logic [3:0] ea [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_load(14'd0, nb);
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== 4'd0 ||
                seen_anode[i] !== ((i == 0) ? 4'b1110 : 4'b1111)) begin
                errors++;
                $display("FAIL scan_0 idx=%0d digit=%0d anode=%b want 0 %b",
                         i, seen_digit[i], seen_anode[i], (i == 0) ? 4'b1110 : 4'b1111);
            end
        end
        do_load(14'd9999, nb);
        checks++;
        if (ovf !== 1'b0 || nb != 14) begin
            errors++;
            $display("FAIL ovf_9999 ovf=%b busy_len=%0d want 0 14", ovf, nb);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_digit[i] !== 4'd9 || seen_anode[i] !== ea[i]) begin
                errors++;
                $display("FAIL scan_9999 idx=%0d digit=%0d anode=%b want 9 %b",
                         i, seen_digit[i], seen_anode[i], ea[i]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        load   = 1'b0;
        value  = '0;
        test_reset();
        test_convert_1234();
        test_overflow();
        test_load_during_busy();
        test_reset_mid_conv();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
